// File: rtl/font_loader_if.sv
// Glyph-upload bus: command-decoder side (load request, byte stream) and font RAM write port.
interface font_loader_if #(
  parameter int CHAR_WIDTH  = 16,
  parameter int RAM_WIDTH   = 15,
  parameter int INDEX_WIDTH = 10
);
  logic                   load_start;
  logic [INDEX_WIDTH-1:0] load_char;
  logic [7:0]             byte_data;
  logic                   byte_valid;
  logic                   byte_ready;
  logic [RAM_WIDTH-1:0]   font_address;
  logic [CHAR_WIDTH-1:0]  font_data;
  logic                   font_write_enable;
  logic                   busy;
  logic                   done;
  logic                   error;

  modport master (
    output load_start, load_char, byte_data, byte_valid,
    input  byte_ready, font_address, font_data, font_write_enable, busy, done, error
  );

  modport slave (
    input  load_start, load_char, byte_data, byte_valid,
    output byte_ready, font_address, font_data, font_write_enable, busy, done, error
  );
endinterface

// File: rtl/font_loader.sv
// Receives a glyph as a byte stream, assembles each row MSB-first and writes it to the font RAM.
module font_loader #(
  parameter int CHAR_WIDTH    = 16,
  parameter int ROWS_PER_CHAR = 20,
  parameter int CHARS         = 1024,
  parameter int RAM_WIDTH     = 15,
  parameter int INDEX_WIDTH   = 10
) (
  input logic          clk,
  input logic          reset,
  font_loader_if.slave bus
);
  localparam int BYTES_PER_ROW = CHAR_WIDTH / 8;
  localparam int CNT_W = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1;
  localparam int ROW_W = (ROWS_PER_CHAR > 1) ? $clog2(ROWS_PER_CHAR) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_ROW - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS_PER_CHAR - 1);

  typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_t;

  state_t                state;
  logic [RAM_WIDTH-1:0]  char_base;
  logic [ROW_W-1:0]      row;
  logic [CNT_W-1:0]      byte_cnt;
  logic [CHAR_WIDTH-1:0] shift;
  logic [CHAR_WIDTH-1:0] shift_next;
  logic                  accept;

  // Older bytes fall off the top, so the first byte of a row lands in the MSBs.
  assign shift_next = CHAR_WIDTH'({shift, bus.byte_data});
  assign accept     = bus.byte_valid & bus.byte_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      char_base             <= '0;
      row                   <= '0;
      byte_cnt              <= '0;
      shift                 <= '0;
      bus.byte_ready        <= 1'b0;
      bus.font_address      <= '0;
      bus.font_data         <= '0;
      bus.font_write_enable <= 1'b0;
      bus.busy              <= 1'b0;
      bus.done              <= 1'b0;
      bus.error             <= 1'b0;
    end else begin
      bus.font_write_enable <= 1'b0;
      bus.done              <= 1'b0;
      bus.error             <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_start) begin
            if (32'(bus.load_char) < CHARS) begin
              char_base      <= RAM_WIDTH'(32'(bus.load_char) * ROWS_PER_CHAR);
              row            <= '0;
              byte_cnt       <= '0;
              state          <= RECEIVE;
              bus.busy       <= 1'b1;
              bus.byte_ready <= 1'b1;
            end else begin
              bus.error <= 1'b1;
            end
          end
        end
        RECEIVE: begin
          if (accept) begin
            shift <= shift_next;
            if (byte_cnt == LAST_BYTE) begin
              // Address and data are registered together with the strobe so they are stable for the whole write.
              byte_cnt              <= '0;
              state                 <= WRITE;
              bus.byte_ready        <= 1'b0;
              bus.font_write_enable <= 1'b1;
              bus.font_address      <= char_base + RAM_WIDTH'(row);
              bus.font_data         <= shift_next;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          if (row == LAST_ROW) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            row            <= row + ROW_W'(1);
            state          <= RECEIVE;
            bus.byte_ready <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_font_loader.sv
// Bench for font_loader: randomized glyph uploads compared against a row-by-row model of the expected RAM writes.
module tb_font_loader;
  localparam int CHAR_WIDTH  = 16;
  localparam int ROWS        = 20;
  localparam int CHARS       = 1024;
  localparam int RAM_WIDTH   = 15;
  // One extra index bit so an out-of-range glyph number such as 1024 can be presented.
  localparam int INDEX_WIDTH = 11;
  localparam int NBYTES      = ROWS * CHAR_WIDTH / 8;

  typedef struct {
    logic [RAM_WIDTH-1:0]  addr;
    logic [CHAR_WIDTH-1:0] data;
    int                    cycle;
  } wr_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  font_loader_if #(.CHAR_WIDTH(CHAR_WIDTH), .RAM_WIDTH(RAM_WIDTH), .INDEX_WIDTH(INDEX_WIDTH)) bus ();

  font_loader #(
    .CHAR_WIDTH(CHAR_WIDTH), .ROWS_PER_CHAR(ROWS), .CHARS(CHARS),
    .RAM_WIDTH(RAM_WIDTH), .INDEX_WIDTH(INDEX_WIDTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int          n_compared;
  int          n_mismatched;
  logic [7:0]  stream [0:NBYTES-1];
  wr_t         wr_q [$];
  int          done_q [$];
  int          cycle = 0;
  int          error_cnt, overlap_cnt, ready_cnt, busy_cnt, busy_gaps;

  // Observes the RAM port and status pulses mid-cycle, when the registered outputs are settled.
  always @(negedge clk) begin
    cycle++;
    if (bus.font_write_enable)
      wr_q.push_back('{addr: bus.font_address, data: bus.font_data, cycle: cycle});
    if (bus.done)                                 done_q.push_back(cycle);
    if (bus.error)                                error_cnt++;
    if (bus.font_write_enable && bus.byte_ready)  overlap_cnt++;
    if (bus.byte_ready)                           ready_cnt++;
    if (bus.busy)                                 busy_cnt++;
  end

  initial begin
    #400_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_monitor();
    @(posedge clk);
    wr_q.delete();
    done_q.delete();
    error_cnt   = 0;
    overlap_cnt = 0;
    ready_cnt   = 0;
    busy_cnt    = 0;
    busy_gaps   = 0;
  endtask

  // Starts an upload of 'glyph' and offers n_bytes of 'stream'; optional random valid gaps and a stray load_start.
  task automatic applyStimulus(input int glyph, input bit gaps, input int intrude_at,
                               input int n_bytes, input bit wait_done);
    int   idx      = 0;
    int   budget   = 0;
    bit   intruded = 1'b0;
    logic ready_now;
    @(negedge clk);
    bus.load_char  = INDEX_WIDTH'(glyph);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    while (idx < n_bytes && budget < 1000) begin
      if (!bus.busy) busy_gaps++;
      if (idx == intrude_at && !intruded) begin
        bus.load_char  = INDEX_WIDTH'(7);
        bus.load_start = 1'b1;
        intruded       = 1'b1;
      end else begin
        bus.load_start = 1'b0;
      end
      bus.byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.byte_data  = stream[idx];
      ready_now      = bus.byte_ready;
      @(negedge clk);
      if (bus.byte_valid && ready_now) idx++;
      budget++;
    end
    bus.byte_valid = 1'b0;
    bus.load_start = 1'b0;
    checkOutput($sformatf("g%0d byte stream timeout", glyph), 64'(budget >= 1000), 0);
    if (wait_done) begin
      budget = 0;
      while (!bus.done && budget < 100) begin
        if (!bus.busy) busy_gaps++;
        @(negedge clk);
        budget++;
      end
      checkOutput($sformatf("g%0d done timeout", glyph), 64'(budget >= 100), 0);
      @(negedge clk);
    end
  endtask

  // Reference: row r of glyph g goes to g*ROWS+r and holds bytes 2r (high) and 2r+1 (low) of the stream.
  task automatic verify_upload(input int glyph, input int n_rows, input bit spacing);
    checkOutput($sformatf("g%0d write count", glyph), wr_q.size(), n_rows);
    for (int r = 0; r < n_rows && r < wr_q.size(); r++) begin
      checkOutput($sformatf("g%0d row%0d addr", glyph, r), wr_q[r].addr, glyph * ROWS + r);
      checkOutput($sformatf("g%0d row%0d data", glyph, r), wr_q[r].data,
                  {stream[2*r], stream[2*r+1]});
      if (spacing && r > 0)
        checkOutput($sformatf("g%0d row%0d spacing", glyph, r), wr_q[r].cycle - wr_q[r-1].cycle, 3);
    end
  endtask

  task automatic check_clean_finish(input int glyph);
    checkOutput($sformatf("g%0d done pulses", glyph), done_q.size(), 1);
    if (done_q.size() > 0 && wr_q.size() > 0)
      checkOutput($sformatf("g%0d done timing", glyph), done_q[0], wr_q[wr_q.size()-1].cycle + 1);
    checkOutput($sformatf("g%0d error pulses", glyph), error_cnt, 0);
    checkOutput($sformatf("g%0d ready during write", glyph), overlap_cnt, 0);
    checkOutput($sformatf("g%0d busy gaps", glyph), busy_gaps, 0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, " write_enable"}, bus.font_write_enable, 0);
    checkOutput({tag, " busy"},         bus.busy, 0);
    checkOutput({tag, " byte_ready"},   bus.byte_ready, 0);
    checkOutput({tag, " done"},         bus.done, 0);
    checkOutput({tag, " error"},        bus.error, 0);
    checkOutput({tag, " address"},      bus.font_address, 0);
    checkOutput({tag, " data"},         bus.font_data, 0);
  endtask

  initial begin
    n_compared     = 0;
    n_mismatched   = 0;
    reset          = 1'b1;
    bus.load_start = 1'b0;
    bus.load_char  = '0;
    bus.byte_data  = '0;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    $display("[TB] glyph 0, counting bytes, no gaps");
    for (int i = 0; i < NBYTES; i++) stream[i] = 8'(i);
    clear_monitor();
    applyStimulus(0, 1'b0, -1, NBYTES, 1'b1);
    verify_upload(0, ROWS, 1'b1);
    check_clean_finish(0);

    $display("[TB] glyph 1023, random bytes");
    for (int i = 0; i < NBYTES; i++) stream[i] = 8'($urandom);
    clear_monitor();
    applyStimulus(1023, 1'b0, -1, NBYTES, 1'b1);
    verify_upload(1023, ROWS, 1'b1);
    check_clean_finish(1023);

    $display("[TB] out-of-range glyph 1024");
    clear_monitor();
    @(negedge clk);
    bus.load_char  = INDEX_WIDTH'(1024);
    bus.load_start = 1'b1;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    checkOutput("bad index error pulse", bus.error, 1);
    @(negedge clk);
    checkOutput("bad index error width", bus.error, 0);
    repeat (10) @(negedge clk);
    bus.byte_valid = 1'b0;
    checkOutput("bad index error count", error_cnt, 1);
    checkOutput("bad index writes", wr_q.size(), 0);
    checkOutput("bad index busy cycles", busy_cnt, 0);
    checkOutput("bad index ready cycles", ready_cnt, 0);

    $display("[TB] glyph 5, counting bytes with random valid gaps");
    for (int i = 0; i < NBYTES; i++) stream[i] = 8'(i);
    clear_monitor();
    applyStimulus(5, 1'b1, -1, NBYTES, 1'b1);
    verify_upload(5, ROWS, 1'b0);
    check_clean_finish(5);

    $display("[TB] glyph 2 aborted by reset mid-row");
    for (int i = 0; i < NBYTES; i++) stream[i] = 8'($urandom);
    clear_monitor();
    applyStimulus(2, 1'b0, -1, 11, 1'b0);
    checkOutput("g2 writes before reset", wr_q.size(), 5);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("after reset");
    reset          = 1'b0;
    bus.byte_valid = 1'b1;
    repeat (20) @(negedge clk);
    bus.byte_valid = 1'b0;
    verify_upload(2, 5, 1'b1);
    checkOutput("g2 done after abort", done_q.size(), 0);
    checkOutput("g2 busy after abort", bus.busy, 0);

    $display("[TB] glyph 3 after the aborted upload");
    for (int i = 0; i < NBYTES; i++) stream[i] = 8'($urandom);
    clear_monitor();
    applyStimulus(3, 1'b1, -1, NBYTES, 1'b1);
    verify_upload(3, ROWS, 1'b0);
    check_clean_finish(3);

    $display("[TB] glyph 4 with a stray load_start for glyph 7");
    for (int i = 0; i < NBYTES; i++) stream[i] = 8'($urandom);
    clear_monitor();
    applyStimulus(4, 1'b0, 9, NBYTES, 1'b1);
    verify_upload(4, ROWS, 1'b1);
    check_clean_finish(4);

    $display("[TB] reset and load_start in the same cycle");
    clear_monitor();
    @(negedge clk);
    reset          = 1'b1;
    bus.load_char  = INDEX_WIDTH'(6);
    bus.load_start = 1'b1;
    @(negedge clk);
    reset          = 1'b0;
    bus.load_start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("reset+start busy cycles", busy_cnt, 0);
    checkOutput("reset+start writes", wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/font_loader.md
Name: font_loader

Overview:
- Write-side companion to the read-only font RAM port used by the character renderer.
- Accepts a glyph upload (character index plus a byte stream of row bitmaps) and issues one RAM write per glyph row on the font RAM's write port.
- Sits between the command/serial decoder that supplies glyph bytes and the font RAM, so fonts can be redefined at run time.

Parameters:
- CHAR_WIDTH, 16: bits per glyph row; must be a multiple of 8. BYTES_PER_ROW = CHAR_WIDTH/8.
- ROWS_PER_CHAR, 20: rows per glyph.
- CHARS, 1024: number of glyphs in the font RAM.
- RAM_WIDTH, 15: font RAM address width; CHARS*ROWS_PER_CHAR must be ≤ 2^RAM_WIDTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle request to begin uploading glyph load_char.
- load_char  input  10  glyph index, sampled when load_start=1 in IDLE.
- byte_data  input  8  glyph byte.
- byte_valid  input  1  byte_data is valid.
- byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid & byte_ready.
- font_address  output  RAM_WIDTH  write address (char_base + row).
- font_data  output  CHAR_WIDTH  assembled row bitmap.
- font_write_enable  output  1  write strobe to the font RAM.
- busy  output  1  upload in progress.
- done  output  1  one-cycle pulse when the glyph's last row has been written.
- error  output  1  one-cycle pulse when load_char ≥ CHARS.

Behaviour:
- Reset values: all outputs 0; internal state IDLE; counters and shift register 0. Reset in any state aborts the upload immediately, with no further writes. Rows already written remain in RAM.
- States: IDLE, RECEIVE, WRITE, DONE.
- IDLE:
  - byte_ready=0, busy=0.
  - load_start with load_char < CHARS: char_base <= load_char*ROWS_PER_CHAR (RAM_WIDTH bits, no overflow by the parameter rule), row <= 0, byte_cnt <= 0, next state RECEIVE.
  - load_start with load_char ≥ CHARS: error=1 on the next cycle; stay IDLE.
- RECEIVE:
  - busy=1, byte_ready=1.
  - Each accepted byte shifts in MSB-first: shift <= {shift[CHAR_WIDTH-9:0], byte_data}. The first byte of a row becomes bits [CHAR_WIDTH-1:CHAR_WIDTH-8].
  - byte_cnt increments per accepted byte. On the byte with byte_cnt = BYTES_PER_ROW-1, go to WRITE and reset byte_cnt to 0.
  - Cycles with byte_valid=0 cause no change. There is no timeout.
- WRITE (exactly one cycle):
  - font_write_enable=1, font_address=char_base+row, font_data=shift, byte_ready=0, busy=1.
  - If row = ROWS_PER_CHAR-1, go to DONE; otherwise row++ and return to RECEIVE.
- DONE (one cycle): done=1, busy=0, byte_ready=0; then IDLE.
- font_write_enable is high only in WRITE. font_address and font_data are don't-care when it is low, but must not glitch during WRITE.
- Write latency: font_write_enable rises on the cycle after the last byte of a row is accepted. Minimum row period is BYTES_PER_ROW+1 cycles.
- load_start while not in IDLE is ignored; no error.
- byte_valid in IDLE or DONE is not accepted (byte_ready=0); the byte stays pending at the source.
- Simultaneous reset and load_start: reset wins.
- Total writes per successful upload: exactly ROWS_PER_CHAR, at consecutive addresses char_base … char_base+ROWS_PER_CHAR-1.

Test Plan:
- Glyph 0, 40 bytes with byte_valid held high (bytes 0x00..0x27):
  - 20 writes, addresses 0..19.
  - First data 0x0001, last 0x2627.
  - Writes spaced 3 cycles apart.
  - done pulses once, one cycle after the 20th write.
- Glyph 1023 upload:
  - Addresses 20460..20479.
  - No write outside that range.
  - busy is high from the cycle after load_start until DONE.
- load_start with load_char=1024:
  - error=1 for one cycle.
  - No writes; busy stays 0; byte_ready stays 0.
- Glyph 5 with random byte_valid gaps, including gaps between the two bytes of a row:
  - Addresses 100..119.
  - Data identical to the no-gap run.
  - No byte is accepted during a WRITE cycle.
- Reset asserted after the 5th write of glyph 2 (mid-row):
  - Next cycle: all outputs 0 and no further font_write_enable.
  - A fresh upload of glyph 3 then writes 60..79 correctly.
- Second load_start (load_char=7) issued during a glyph 4 upload:
  - Ignored; writes stay 80..99.
  - A single done pulse; no error.
